serial_negate_param: RTL and testbench



---
 rtl/serial_negate_param_if.sv | 22 ++
 rtl/serial_negate_param.sv | 80 ++++++++
 tb/tb_serial_negate_param.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_negate_param_if.sv
// Bit-serial word stream: LSB-first data in with word sync and operation
// select, one registered result bit out with word-end and overflow flags.
interface serial_negate_param_if;
  logic       xin;
  logic       xin_valid;
  logic       sync;
  logic [1:0] mode;
  logic       yout;
  logic       yout_valid;
  logic       yout_last;
  logic       ovf;

  modport master (
    output xin, xin_valid, sync, mode,
    input  yout, yout_valid, yout_last, ovf
  );

  modport slave (
    input  xin, xin_valid, sync, mode,
    output yout, yout_valid, yout_last, ovf
  );
endinterface

// File: rtl/serial_negate_param.sv
// Bit-serial pass / ones' complement / two's complement of WIDTH-bit words,
// LSB first, one result bit per input bit with a single cycle of latency.
// Two's complement uses the classic rule: copy bits up to and including the
// first 1, invert every bit after it.
module serial_negate_param #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  serial_negate_param_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    SEEK,
    INVERT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [1:0]       mode_q;

  logic [IDX_W-1:0] cur_idx;
  logic             word_start;
  logic [1:0]       cur_mode;
  state_t           cur_state;
  state_t           next_state;
  logic             res_bit;
  logic             is_last;
  logic             is_ovf;

  // Resolve this bit's position, mode and state; a qualified sync restarts the word here.
  always_comb begin
    cur_idx    = bus.sync ? '0 : idx;
    word_start = (cur_idx == '0);
    cur_mode   = word_start ? bus.mode : mode_q;
    cur_state  = word_start ? SEEK : state;
    is_last    = (cur_idx == LAST_IDX);
    next_state = cur_state;
    res_bit    = bus.xin;
    case (cur_mode)
      2'b00: res_bit = bus.xin;
      2'b01: res_bit = ~bus.xin;
      default: begin
        res_bit = (cur_state == INVERT) ? ~bus.xin : bus.xin;
        if (bus.xin) next_state = INVERT;
      end
    endcase
    is_ovf = is_last && cur_mode[1] && (cur_state == SEEK) && bus.xin;
  end

  // Advance word position and state on valid bits only; outputs are registered and idle to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx            <= '0;
      state          <= SEEK;
      mode_q         <= 2'b00;
      bus.yout       <= 1'b0;
      bus.yout_valid <= 1'b0;
      bus.yout_last  <= 1'b0;
      bus.ovf        <= 1'b0;
    end else if (bus.xin_valid) begin
      idx            <= is_last ? '0 : cur_idx + IDX_W'(1);
      state          <= is_last ? SEEK : next_state;
      mode_q         <= cur_mode;
      bus.yout       <= res_bit;
      bus.yout_valid <= 1'b1;
      bus.yout_last  <= is_last;
      bus.ovf        <= is_ovf;
    end else begin
      bus.yout       <= 1'b0;
      bus.yout_valid <= 1'b0;
      bus.yout_last  <= 1'b0;
      bus.ovf        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_negate_param.sv
// Bench for serial_negate_param: a 4-bit and an 8-bit instance see the same
// input stream, each followed by a word-level arithmetic reference model.
module tb_serial_negate_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_negate_param_if b4 ();
  serial_negate_param_if b8 ();

  serial_negate_param #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
  serial_negate_param #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8.slave));

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance (0: WIDTH=4, 1: WIDTH=8)
  int               mw [2] = '{4, 8};
  int               m_idx [2];
  logic [1:0]       m_mode [2];
  longint unsigned  m_acc [2];
  logic             e_yout [2];
  logic             e_valid [2];
  logic             e_last [2];
  logic             e_ovf [2];

  // Captured result bits (LSB first) for word-level checks
  logic [15:0] cap4;
  logic [15:0] cap8;
  int          cnt4, cnt8, last4_cnt, last4_pos;
  logic        ovf4_seen, ovf8_seen;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_capture();
    cap4 = '0; cap8 = '0;
    cnt4 = 0; cnt8 = 0; last4_cnt = 0; last4_pos = 0;
    ovf4_seen = 1'b0; ovf8_seen = 1'b0;
  endtask

  task automatic model_step(input int k, input logic r, input logic x, input logic v,
                            input logic s, input logic [1:0] md);
    longint unsigned neg;
    e_yout[k] = 1'b0; e_valid[k] = 1'b0; e_last[k] = 1'b0; e_ovf[k] = 1'b0;
    if (r) begin
      m_idx[k] = 0; m_mode[k] = 2'b00; m_acc[k] = 0;
    end else if (v) begin
      if (s || m_idx[k] == 0) begin
        m_idx[k] = 0; m_mode[k] = md; m_acc[k] = 0;
      end
      if (x) m_acc[k] = m_acc[k] | (64'd1 << m_idx[k]);
      neg = 64'd0 - m_acc[k];
      e_valid[k] = 1'b1;
      case (m_mode[k])
        2'b00:   e_yout[k] = x;
        2'b01:   e_yout[k] = ~x;
        default: e_yout[k] = neg[m_idx[k]];
      endcase
      e_last[k] = (m_idx[k] == mw[k] - 1);
      e_ovf[k]  = e_last[k] && m_mode[k][1] && (m_acc[k] == (64'd1 << (mw[k] - 1)));
      m_idx[k]  = e_last[k] ? 0 : m_idx[k] + 1;
    end
  endtask

  task automatic checkOutput();
    check_value("w4_yout_valid", b4.yout_valid, e_valid[0]);
    check_value("w4_yout",       b4.yout,       e_yout[0]);
    check_value("w4_yout_last",  b4.yout_last,  e_last[0]);
    check_value("w4_ovf",        b4.ovf,        e_ovf[0]);
    check_value("w8_yout_valid", b8.yout_valid, e_valid[1]);
    check_value("w8_yout",       b8.yout,       e_yout[1]);
    check_value("w8_yout_last",  b8.yout_last,  e_last[1]);
    check_value("w8_ovf",        b8.ovf,        e_ovf[1]);
    if (b4.yout_valid === 1'b1) begin
      if (cnt4 < 16) cap4[cnt4] = b4.yout;
      cnt4++;
      if (b4.yout_last === 1'b1) begin last4_cnt++; last4_pos = cnt4; end
    end
    if (b4.ovf === 1'b1) ovf4_seen = 1'b1;
    if (b8.yout_valid === 1'b1) begin
      if (cnt8 < 16) cap8[cnt8] = b8.yout;
      cnt8++;
    end
    if (b8.ovf === 1'b1) ovf8_seen = 1'b1;
  endtask

  task automatic applyStimulus(input logic r, input logic x, input logic v,
                               input logic s, input logic [1:0] md);
    reset = r;
    b4.xin = x; b4.xin_valid = v; b4.sync = s; b4.mode = md;
    b8.xin = x; b8.xin_valid = v; b8.sync = s; b8.mode = md;
    model_step(0, r, x, v, s, md);
    model_step(1, r, x, v, s, md);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic send_word(input logic [7:0] bits, input int n, input logic [1:0] md);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, bits[i], 1'b1, 1'b0, md);
  endtask

  task automatic idle(input int n, input logic [1:0] md);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, md);
  endtask

  initial begin
    reset = 1'b1;
    b4.xin = 1'b0; b4.xin_valid = 1'b0; b4.sync = 1'b0; b4.mode = 2'b00;
    b8.xin = 1'b0; b8.xin_valid = 1'b0; b8.sync = 1'b0; b8.mode = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_mode[k] = 2'b00; m_acc[k] = 0;
    end
    clear_capture();

    // Reset state
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
    check_value("reset_yout_valid", b4.yout_valid, 1'b0);
    idle(1, 2'b00);

    // +6 negated -> -6 (1010), last on 4th, no overflow
    clear_capture();
    send_word(8'h06, 4, 2'b10);
    check_value("neg6_word", cap4[3:0], 4'b1010);
    check_value("neg6_last_pos", last4_pos, 4);
    check_value("neg6_ovf", ovf4_seen, 1'b0);

    // -8 negated overflows, back-to-back with the previous word
    clear_capture();
    send_word(8'h08, 4, 2'b10);
    check_value("neg8_word", cap4[3:0], 4'b1000);
    check_value("neg8_last_pos", last4_pos, 4);
    check_value("neg8_ovf", ovf4_seen, 1'b1);

    // Ones' complement then pass, mode changing per word
    clear_capture();
    send_word(8'h05, 4, 2'b01);
    send_word(8'h03, 4, 2'b00);
    check_value("ones_pass_words", cap4[7:0], 8'h3A);
    check_value("ones_pass_ovf", ovf4_seen, 1'b0);

    // Valid gaps of 0, 2 and 3 cycles inside a two's complement word (mode 11 mid-word ignored)
    clear_capture();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
    idle(2, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
    idle(3, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    idle(1, 2'b10);
    check_value("gap_pulse_count", cnt4, 4);
    check_value("gap_word", cap4[3:0], 4'b0011);

    // Sync aborts a partial word; new word 1,0,0,0 -> 1,1,1,1
    clear_capture();
    send_word(8'h01, 2, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b10);
    send_word(8'h00, 3, 2'b10);
    check_value("sync_bits", cap4[5:0], 6'b111111);
    check_value("sync_last_count", last4_cnt, 1);
    check_value("sync_last_pos", last4_pos, 6);

    // Reset mid-word, then a clean word from bit 0
    send_word(8'h03, 2, 2'b10);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
    check_value("midreset_valid", b4.yout_valid, 1'b0);
    clear_capture();
    send_word(8'h02, 4, 2'b10);
    check_value("after_reset_word", cap4[3:0], 4'b1110);

    // Realign both instances, then the 8-bit most negative value
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    clear_capture();
    send_word(8'h80, 8, 2'b10);
    check_value("w8_neg128_word", cap8[7:0], 8'h80);
    check_value("w8_neg128_ovf", ovf8_seen, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    1'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 9) == 0),
                    2'($urandom));
    end
    idle(2, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
